enemy_squad_controller: RTL

Parametrised successor to the single-enemy Level-2 controller. Drives NUM_ENEMY patrolling enemies on separate rows and a shared pool of NUM_PROJ falling projectiles. Enemies fire in round-robin order, and a projectile is consumed when it hits the player. Sits between the game-tick generator and the renderer/collision-to-lives logic; outputs are flattened buses.

---
 rtl/enemy_squad_controller.sv | 258 +++++++++++++++++++++++++
 1 files changed

// File: rtl/enemy_squad_controller.sv
// enemy_squad_controller
// Drives NUM_ENEMY patrolling enemies, one per row, and a shared pool of
// NUM_PROJ falling projectiles. Enemies take turns firing. A projectile is
// consumed when it touches the player.
// All state advances only on game_tick, and only while freeze is low.
// Optional build macro: AIMED_SHOT_EN. When it is defined, each projectile
// also drifts horizontally towards where the player stood at spawn time.
module enemy_squad_controller #(
    parameter int NUM_ENEMY    = 2,
    parameter int NUM_PROJ     = 8,
    parameter int ACTIVE_LEVEL = 1,
    parameter int PATROL_X_MIN = 120,
    parameter int PATROL_X_MAX = 580,
    parameter int STAGGER_X    = 64,
    parameter int ENEMY_Y0     = 120,
    parameter int ROW_PITCH    = 40,
    parameter int ENEMY_SPEED  = 3,
    parameter int PROJ_SPEED   = 6,
    parameter int SHOOT_PERIOD = 20
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      game_tick,
    input  logic                      freeze,
    input  logic [1:0]                level,
    input  logic [9:0]                player_x,
    input  logic [9:0]                player_y,
    output logic [10*NUM_ENEMY-1:0]   enemy_x_flat,
    output logic [10*NUM_ENEMY-1:0]   enemy_y_flat,
    output logic [10*NUM_PROJ-1:0]    proj_x_flat,
    output logic [10*NUM_PROJ-1:0]    proj_y_flat,
    output logic [NUM_PROJ-1:0]       proj_active,
    output logic                      hit_enemy
);

    localparam int PW = (NUM_PROJ > 1) ? $clog2(NUM_PROJ) : 1;
    localparam int SW = (NUM_ENEMY > 1) ? $clog2(NUM_ENEMY) : 1;
    localparam int TW = (SHOOT_PERIOD > 0) ? $clog2(SHOOT_PERIOD + 1) : 1;

    // Enemy rows never change, so y is a function of the enemy index.
    function automatic logic [9:0] row_y(input int k);
        return 10'(ENEMY_Y0 + k * ROW_PITCH);
    endfunction

    function automatic logic [9:0] init_x(input int k);
        return 10'(PATROL_X_MIN + k * STAGGER_X);
    endfunction

    logic [NUM_ENEMY-1:0][9:0] ex_q, ex_d;
    logic [NUM_ENEMY-1:0]      dir_q, dir_d;     // 1 = moving right
    logic [NUM_PROJ-1:0][9:0]  px_q, px_d;
    logic [NUM_PROJ-1:0][9:0]  py_q, py_d;
    logic [NUM_PROJ-1:0]       act_q, act_d;
    logic [TW-1:0]             timer_q, timer_d;
    logic [SW-1:0]             shooter_q, shooter_d;
`ifdef AIMED_SHOT_EN
    logic [NUM_PROJ-1:0][2:0]  dx_q, dx_d;       // two's complement x step
    logic signed [11:0]        nx;
`endif

    logic                 level_ok;
    logic                 run_tick;
    logic                 init_tick;
    logic [NUM_ENEMY-1:0] enemy_ov;
    logic [NUM_PROJ-1:0]  proj_ov;
    logic [PW-1:0]        free_idx;
    logic                 free_found;
    logic                 fire;
    logic [9:0]           shot_x;
    logic [9:0]           shot_y;

    assign level_ok  = (level == 2'(ACTIVE_LEVEL));
    assign run_tick  = game_tick && !freeze && level_ok;
    assign init_tick = game_tick && !freeze && !level_ok;
    assign fire      = (timer_q == '0);

    // Player-vs-object overlap. The edges are inclusive, and the math is done
    // in 11 bits so that the +width terms cannot wrap.
    always_comb begin
        enemy_ov = '0;
        proj_ov  = '0;
        for (int k = 0; k < NUM_ENEMY; k++) begin
            enemy_ov[k] = ({1'b0, player_x} <= {1'b0, ex_q[k]} + 11'd16) &&
                          ({1'b0, ex_q[k]} <= {1'b0, player_x} + 11'd16) &&
                          ({1'b0, player_y} <= {1'b0, row_y(k)} + 11'd16) &&
                          ({1'b0, row_y(k)} <= {1'b0, player_y} + 11'd16);
        end
        for (int j = 0; j < NUM_PROJ; j++) begin
            proj_ov[j] = act_q[j] &&
                         ({1'b0, player_x} <= {1'b0, px_q[j]} + 11'd5) &&
                         ({1'b0, px_q[j]} <= {1'b0, player_x} + 11'd16) &&
                         ({1'b0, player_y} <= {1'b0, py_q[j]} + 11'd12) &&
                         ({1'b0, py_q[j]} <= {1'b0, player_y} + 11'd16);
        end
    end

    // Find the lowest slot that is free at the start of the tick, and the
    // spawn point of the enemy whose turn it is.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int j = NUM_PROJ - 1; j >= 0; j--) begin
            if (!act_q[j]) begin
                free_found = 1'b1;
                free_idx   = PW'(j);
            end
        end
        shot_x = '0;
        shot_y = '0;
        for (int k = 0; k < NUM_ENEMY; k++) begin
            if (shooter_q == SW'(k)) begin
                shot_x = ex_q[k] + 10'd6;
                shot_y = row_y(k) + 10'd16;
            end
        end
    end

    // Next state for one active game tick: patrol, fall, fire.
    always_comb begin
        ex_d      = ex_q;
        dir_d     = dir_q;
        px_d      = px_q;
        py_d      = py_q;
        act_d     = act_q;
        timer_d   = timer_q;
        shooter_d = shooter_q;
`ifdef AIMED_SHOT_EN
        dx_d      = dx_q;
        nx        = '0;
`endif
        for (int k = 0; k < NUM_ENEMY; k++) begin
            if (dir_q[k]) begin
                if ({1'b0, ex_q[k]} + 11'(16 + ENEMY_SPEED) <= 11'(PATROL_X_MAX)) begin
                    ex_d[k] = ex_q[k] + 10'(ENEMY_SPEED);
                end else begin
                    ex_d[k]  = 10'(PATROL_X_MAX - 16);
                    dir_d[k] = 1'b0;
                end
            end else begin
                if ({1'b0, ex_q[k]} >= 11'(PATROL_X_MIN + ENEMY_SPEED)) begin
                    ex_d[k] = ex_q[k] - 10'(ENEMY_SPEED);
                end else begin
                    ex_d[k]  = 10'(PATROL_X_MIN);
                    dir_d[k] = 1'b1;
                end
            end
        end

        for (int j = 0; j < NUM_PROJ; j++) begin
            if (act_q[j]) begin
                if (proj_ov[j] ||
                    ({1'b0, py_q[j]} + 11'(12 + PROJ_SPEED) >= 11'd480)) begin
                    act_d[j] = 1'b0;
`ifdef AIMED_SHOT_EN
                    dx_d[j]  = 3'd0;
`endif
                end else begin
                    py_d[j] = py_q[j] + 10'(PROJ_SPEED);
`ifdef AIMED_SHOT_EN
                    nx = $signed({2'b00, px_q[j]}) + $signed({{9{dx_q[j][2]}}, dx_q[j]});
                    if (nx < 12'sd0) begin
                        px_d[j] = 10'd0;
                        dx_d[j] = 3'd0;
                    end else if (nx > 12'sd634) begin
                        px_d[j] = 10'd634;
                        dx_d[j] = 3'd0;
                    end else begin
                        px_d[j] = nx[9:0];
                    end
`endif
                end
            end else if (fire && free_found && (free_idx == PW'(j))) begin
                // The spawn slot was free at tick start, so it skips the fall step.
                act_d[j] = 1'b1;
                px_d[j]  = shot_x;
                py_d[j]  = shot_y;
`ifdef AIMED_SHOT_EN
                if ({1'b0, player_x} + 11'd8 > {1'b0, shot_x} + 11'd2) begin
                    dx_d[j] = 3'd2;
                end else if ({1'b0, player_x} + 11'd8 < {1'b0, shot_x} + 11'd2) begin
                    dx_d[j] = 3'b110;
                end else begin
                    dx_d[j] = 3'd0;
                end
`endif
            end
        end

        if (fire) begin
            timer_d   = TW'(SHOOT_PERIOD);
            shooter_d = (shooter_q == SW'(NUM_ENEMY - 1)) ? '0 : shooter_q + SW'(1);
        end else begin
            timer_d = timer_q - TW'(1);
        end
    end

    // State register. It loads the init state on reset or on an off-level
    // tick, and loads the next state on an active tick.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NUM_ENEMY; k++) begin
                ex_q[k]  <= init_x(k);
                dir_q[k] <= (k % 2 == 0);
            end
            px_q      <= '0;
            py_q      <= '0;
            act_q     <= '0;
            timer_q   <= TW'(SHOOT_PERIOD);
            shooter_q <= '0;
`ifdef AIMED_SHOT_EN
            dx_q      <= '0;
`endif
        end else if (init_tick) begin
            for (int k = 0; k < NUM_ENEMY; k++) begin
                ex_q[k]  <= init_x(k);
                dir_q[k] <= (k % 2 == 0);
            end
            px_q      <= '0;
            py_q      <= '0;
            act_q     <= '0;
            timer_q   <= TW'(SHOOT_PERIOD);
            shooter_q <= '0;
`ifdef AIMED_SHOT_EN
            dx_q      <= '0;
`endif
        end else if (run_tick) begin
            ex_q      <= ex_d;
            dir_q     <= dir_d;
            px_q      <= px_d;
            py_q      <= py_d;
            act_q     <= act_d;
            timer_q   <= timer_d;
            shooter_q <= shooter_d;
`ifdef AIMED_SHOT_EN
            dx_q      <= dx_d;
`endif
        end
    end

    // Flatten the registered state onto the output buses.
    always_comb begin
        enemy_x_flat = '0;
        enemy_y_flat = '0;
        proj_x_flat  = '0;
        proj_y_flat  = '0;
        for (int k = 0; k < NUM_ENEMY; k++) begin
            enemy_x_flat[10*k +: 10] = ex_q[k];
            enemy_y_flat[10*k +: 10] = row_y(k);
        end
        for (int j = 0; j < NUM_PROJ; j++) begin
            proj_x_flat[10*j +: 10] = px_q[j];
            proj_y_flat[10*j +: 10] = py_q[j];
        end
        proj_active = act_q;
        hit_enemy   = level_ok && ((|enemy_ov) || (|proj_ov));
    end

endmodule
